fast_accel_udiv_32ns_16ns_seq: RTL and testbench
================================================

// Module: fast_accel_udiv_32ns_16ns_seq
// PURPOSE
//   Iterative unsigned divider: 32-bit dividend / 16-bit divisor -> quotient + remainder.
//   Inverse of the 16x16 pipelined DSP multiplier in the fast_accel datapath.
//   Used for normalisation and scale recovery after products are formed.
//   Restoring algorithm, one quotient bit per cycle, valid/ready on both sides.
// PARAMETERS
//   DIVIDEND_W  32  dividend and quotient width
//   DIVISOR_W   16  divisor and remainder width
// PORTS
//   clk        in   1            clock; all state updates on posedge
//   reset      in   1            asynchronous, active-high reset
//   ce         in   1            clock enable; 0 freezes all state, outputs hold
//   in_valid   in   1            dividend/divisor valid
//   in_ready   out  1            divider idle and able to accept
//   dividend   in   DIVIDEND_W   unsigned dividend
//   divisor    in   DIVISOR_W    unsigned divisor
//   out_valid  out  1            quotient/remainder valid
//   out_ready  in   1            consumer accepts result
//   quotient   out  DIVIDEND_W   unsigned quotient
//   remainder  out  DIVISOR_W    unsigned remainder
//   dbz        out  1            divisor was zero (only with FAST_ACCEL_UDIV_DBZ_FLAG_EN)
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; dbz=0; count=0.
//   FSM: IDLE -> BUSY on ce & in_valid & in_ready; operands registered at that edge.
//        BUSY -> DONE after exactly DIVIDEND_W ce-qualified BUSY cycles (count DIVIDEND_W-1 -> 0).
//        DONE -> IDLE on ce & out_ready. No other transitions.
//   in_ready = (state==IDLE); out_valid = (state==DONE); both registered-state decodes.
//   No input acceptance in BUSY or DONE; throughput 1 result per DIVIDEND_W+2 cycles minimum.
//   Latency: out_valid rises DIVIDEND_W ce-high cycles after the accept edge.
//   Step, MSB first: t = {r[DIVISOR_W-1:0], next dividend bit} (DIVISOR_W+1 bits);
//     t >= {1'b0,divisor}: r = t - divisor, qbit = 1; else r = t[DIVISOR_W-1:0], qbit = 0.
//   The subtraction is DIVISOR_W+1 wide; carry is never dropped.
//   quotient/remainder update only on BUSY->DONE; held stable through DONE and IDLE until next result.
//   Divisor 0: no special path; the algorithm yields quotient = all ones and
//     remainder = dividend[DIVISOR_W-1:0]. Latency is unchanged.
//   ce=0 in any state: no transition, no count change, no step; handshakes ignored that cycle.
//   out_valid held with out_ready=0: result and out_valid stay frozen indefinitely.
//   Reset mid-operation: asynchronous return to the reset values; the in-flight result is discarded.
// CONFIGURATION
//   FAST_ACCEL_UDIV_DBZ_FLAG_EN defined:
//     - dbz port exists; registered at accept as (divisor==0).
//     - dbz is valid with out_valid and held with the result.
//   Not defined: dbz port absent; divide-by-zero is undetectable except by the result pattern.
// STRUCTURE
//   Package fast_accel_udiv_pkg:
//     - state enum {IDLE, BUSY, DONE}
//     - DIVIDEND_W/DIVISOR_W defaults
//     - count width = $clog2(DIVIDEND_W)
//   Sub-module fast_accel_udiv_step: purely combinational one-bit restoring step.
//     - inputs: r, dividend bit, divisor
//     - outputs: next r, qbit
//   Top module: FSM, counter, and shift registers for dividend/quotient.
// TESTING
//   100 / 7 -> quotient=14, remainder=2; out_valid exactly 32 cycles after accept.
//   0xFFFFFFFF / 0xFFFF -> quotient=0x00010001, remainder=0x0000.
//   0x12345678 / 0 -> quotient=0xFFFFFFFF, remainder=0x5678; dbz=1 when macro defined.
//   5 / 9 -> quotient=0, remainder=5; out_ready low 10 cycles: out_valid and result stable,
//     in_ready=0 throughout.
//   ce toggled 0/1 every other cycle during 1000 / 3 -> quotient=333, remainder=1,
//     out_valid after 32 ce-high cycles.
//   reset pulsed at BUSY cycle 10 -> in_ready=1, out_valid=0 immediately; next 50 / 5 -> quotient=10, remainder=0.

Source files
------------

// File: rtl/fast_accel_udiv_pkg.sv
// Shared types and defaults for the fast_accel iterative unsigned divider.
package fast_accel_udiv_pkg;

    localparam int DEF_DIVIDEND_W = 32;
    localparam int DEF_DIVISOR_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } udiv_state_e;

    // Step counter width: it runs DIVIDEND_W-1 down to 0.
    function automatic int cnt_width(input int dividendW);
        return $clog2(dividendW);
    endfunction

endpackage

// File: rtl/fast_accel_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module fast_accel_udiv_step
    import fast_accel_udiv_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W-1:0] r_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] r_o,
    output logic                 qbit_o
);

    logic [DIVISOR_W:0] trial;
    logic [DIVISOR_W:0] divisorExt;

    // The trial value is one bit wider than the remainder so a set top bit
    // always compares as larger than any divisor.
    always_comb begin
        trial      = {r_i, bit_i};
        divisorExt = {1'b0, divisor_i};
        qbit_o     = (trial >= divisorExt);
        if (qbit_o) begin
            r_o = DIVISOR_W'(trial - divisorExt);
        end else begin
            r_o = trial[DIVISOR_W-1:0];
        end
    end

endmodule

// File: rtl/fast_accel_udiv_32ns_16ns_seq.sv
// Iterative restoring unsigned divider, one quotient bit per ce-high cycle,
// valid/ready on both sides. Optional dbz flag: FAST_ACCEL_UDIV_DBZ_FLAG_EN.
module fast_accel_udiv_32ns_16ns_seq
    import fast_accel_udiv_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
    ,
    output logic                  dbz
`endif
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    udiv_state_e           state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DIVIDEND_W-1:0] work_q, work_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  remOut_q, remOut_d;
    logic [DIVISOR_W-1:0]  stepRem;
    logic                  stepQbit;
`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
    logic                  dbz_q, dbz_d;
`endif

    fast_accel_udiv_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .r_i      (rem_q),
        .bit_i    (work_q[DIVIDEND_W-1]),
        .divisor_i(dvs_q),
        .r_o      (stepRem),
        .qbit_o   (stepQbit)
    );

    // work_q shifts dividend bits out of its MSB while quotient bits enter at
    // its LSB, so after the last step it holds the full quotient.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quot_d   = quot_q;
        remOut_d = remOut_q;
`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
        dbz_d    = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (ce && in_valid) begin
                    state_d = BUSY;
                    count_d = CNT_W'(DIVIDEND_W - 1);
                    work_d  = dividend;
                    rem_d   = '0;
                    dvs_d   = divisor;
`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
                    dbz_d   = (divisor == '0);
`endif
                end
            end
            BUSY: begin
                if (ce) begin
                    work_d = {work_q[DIVIDEND_W-2:0], stepQbit};
                    rem_d  = stepRem;
                    if (count_q == '0) begin
                        state_d  = DONE;
                        quot_d   = {work_q[DIVIDEND_W-2:0], stepQbit};
                        remOut_d = stepRem;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (ce && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            work_q   <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quot_q   <= '0;
            remOut_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quot_q   <= quot_d;
            remOut_q <= remOut_d;
        end
    end

`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign dbz = dbz_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = remOut_q;

endmodule

// File: tb/tb_fast_accel_udiv_32ns_16ns_seq.sv
// Self-checking bench for fast_accel_udiv_32ns_16ns_seq: vector table, corner
// sequences and randomized operands against an arithmetic reference model.
module tb_fast_accel_udiv_32ns_16ns_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
    logic        dbz;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [31:0] expQ;
        logic [15:0] expR;
        logic        expDbz;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    fast_accel_udiv_32ns_16ns_seq dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder)
`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
        ,
        .dbz      (dbz)
`endif
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the all-ones / low-bits pattern for divisor 0.
    task automatic refDivide(input logic [31:0] a, input logic [15:0] b,
                             output logic [31:0] q, output logic [15:0] r);
        if (b == 16'd0) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
        end else begin
            q = a / {16'd0, b};
            r = 16'(a % {16'd0, b});
        end
    endtask

    // Issues one operation from a negedge and returns edges from accept to out_valid.
    task automatic applyStimulus(input logic [31:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consumeResult(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " out_valid after consume"}, {31'd0, out_valid}, 32'd0);
        checkOutput({name, " in_ready after consume"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic checkResult(input string name, input int lat, input logic [31:0] expQ,
                               input logic [15:0] expR, input logic expDbz);
        checkOutput({name, " latency"}, lat, 32'd32);
        checkOutput({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({name, " quotient"}, quotient, expQ);
        checkOutput({name, " remainder"}, {16'd0, remainder}, {16'd0, expR});
`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
        checkOutput({name, " dbz"}, {31'd0, dbz}, {31'd0, expDbz});
`else
        if (expDbz !== expDbz) $display("[TB] unreachable");
`endif
    endtask

    initial begin
        int lat;
        int high;
        int cyc;
        logic [31:0] a;
        logic [31:0] q;
        logic [15:0] b;
        logic [15:0] r;

        vecs[0] = '{32'd100,        16'd7,      32'd14,         16'd2,      1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'h0000,   1'b0};
        vecs[2] = '{32'h1234_5678,  16'd0,      32'hFFFF_FFFF,  16'h5678,   1'b1};
        vecs[3] = '{32'd5,          16'd9,      32'd0,          16'd5,      1'b0};
        vecs[4] = '{32'd1000,       16'd3,      32'd333,        16'd1,      1'b0};
        vecs[5] = '{32'd50,         16'd5,      32'd10,         16'd0,      1'b0};
        vecs[6] = '{32'd0,          16'd1,      32'd0,          16'd0,      1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  16'd1,      32'hFFFF_FFFF,  16'd0,      1'b0};

        reset     = 1'b1;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset quotient", quotient, 32'd0);
        checkOutput("reset remainder", {16'd0, remainder}, 32'd0);
`ifdef FAST_ACCEL_UDIV_DBZ_FLAG_EN
        checkOutput("reset dbz", {31'd0, dbz}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs, lat);
            checkResult($sformatf("vec%0d", i), lat, vecs[i].expQ, vecs[i].expR, vecs[i].expDbz);
            consumeResult($sformatf("vec%0d", i));
        end

        // Result must stay frozen while the consumer stalls, and new requests are ignored.
        applyStimulus(32'd5, 16'd9, lat);
        checkResult("hold 5/9", lat, 32'd0, 16'd5, 1'b0);
        dividend = 32'd77;
        divisor  = 16'd2;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            checkOutput($sformatf("hold%0d quotient", k), quotient, 32'd0);
            checkOutput($sformatf("hold%0d remainder", k), {16'd0, remainder}, 32'd5);
        end
        in_valid = 1'b0;
        consumeResult("hold 5/9");

        // With ce low in IDLE a valid request must not be taken.
        ce       = 1'b0;
        in_valid = 1'b1;
        dividend = 32'd9;
        divisor  = 16'd4;
        repeat (3) @(negedge clk);
        checkOutput("ce0 idle in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        ce       = 1'b1;
        @(negedge clk);
        checkOutput("ce0 idle no accept", {31'd0, in_ready}, 32'd1);

        // ce toggles every cycle; progress is counted in ce-high edges only.
        dividend = 32'd1000;
        divisor  = 16'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ce       = 1'b0;
        high     = 0;
        cyc      = 0;
        while (!out_valid && cyc < 300) begin
            if (ce) high++;
            @(negedge clk);
            cyc++;
            ce = ~ce;
        end
        ce = 1'b1;
        checkOutput("ce toggle high cycles", high, 32'd32);
        checkOutput("ce toggle quotient", quotient, 32'd333);
        checkOutput("ce toggle remainder", {16'd0, remainder}, 32'd1);
        ce        = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("ce0 done holds out_valid", {31'd0, out_valid}, 32'd1);
        ce = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("ce1 done releases", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of an operation.
        dividend = 32'hDEAD_BEEF;
        divisor  = 16'h1234;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("midreset busy in_ready", {31'd0, in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midreset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset quotient", quotient, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(32'd50, 16'd5, lat);
        checkResult("after reset 50/5", lat, 32'd10, 16'd0, 1'b0);
        consumeResult("after reset 50/5");

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'hFFFF - 16'($urandom_range(0, 3));
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 4) == 0) a = a & 32'h0000_FFFF;
            refDivide(a, b, q, r);
            applyStimulus(a, b, lat);
            checkResult($sformatf("rand%0d %08h/%04h", n, a, b), lat, q, r, (b == 16'd0));
            consumeResult($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
